serial_div_border: RTL

- Binary-serial signed restoring divider for the border column of the binary-serial array; the inverse of the serial shift-add multiply border cell.
- Takes a 2*WIDTH-bit dividend (the product-width accumulator) and a WIDTH-bit divisor.
- Produces one quotient bit per cycle, MSB first, then applies a sign fix.
- Valid/ready on both sides so it can sit between the accumulator drain and the output writeback.

---
 rtl/serial_div_pkg.sv | 35 +++
 rtl/serial_div_step.sv | 30 +++
 rtl/serial_div_border.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/serial_div_pkg.sv
// Shared types and helpers for the binary-serial signed restoring divider.
package serial_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Default operand width and the partial-remainder width that goes with it.
  // The extra bit lets the magnitude of the most-negative divisor be held.
  localparam int DIV_WIDTH = 8;
  localparam int REM_EXT_W = DIV_WIDTH + 1;

  // Widest operand the magnitude helper accepts.
  localparam int ABS_MAX_W = 64;

  // Magnitude of a two's-complement value of the given width, returned with
  // one spare bit so -2^(width-1) maps to +2^(width-1) without wrapping.
  // The caller zero-extends its operand into the ABS_MAX_W-bit argument.
  function automatic logic [ABS_MAX_W:0] abs_ext(input logic [ABS_MAX_W-1:0] value,
                                                 input int width);
    logic [ABS_MAX_W:0] mask;
    logic [ABS_MAX_W:0] wide;
    mask = ((ABS_MAX_W+1)'(1) << width) - (ABS_MAX_W+1)'(1);
    wide = {1'b0, value} & mask;
    if (value[width-1]) begin
      abs_ext = (wide ^ mask) + (ABS_MAX_W+1)'(1);
    end else begin
      abs_ext = wide;
    end
  endfunction

endpackage

// File: rtl/serial_div_step.sv
// One combinational restoring-division step: shift a bit into the partial
// remainder and subtract the divisor magnitude when it fits.
import serial_div_pkg::*;

module serial_div_step #(
  parameter int EXT_W = REM_EXT_W
) (
  input  logic [EXT_W-1:0] pr,
  input  logic             bit_in,
  input  logic [EXT_W-1:0] dsr,
  output logic [EXT_W-1:0] pr_next,
  output logic             q_bit
);

  logic [EXT_W:0] wide;

  // Trial subtract; the remainder after a successful subtract is < dsr so it
  // always fits back into EXT_W bits.
  always_comb begin
    wide = {pr, bit_in};
    if (wide >= {1'b0, dsr}) begin
      q_bit   = 1'b1;
      pr_next = wide[EXT_W-1:0] - dsr;
    end else begin
      q_bit   = 1'b0;
      pr_next = wide[EXT_W-1:0];
    end
  end

endmodule

// File: rtl/serial_div_border.sv
// Border-column serial signed divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per cycle MSB first, then a sign-fix cycle.
import serial_div_pkg::*;

module serial_div_border #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [2*WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0]   o_remainder,
  output logic               o_dbz,
  output logic               o_ovf
);

  localparam int EXT_W = WIDTH + 1;

  div_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] dvd;     // dividend magnitude, quotient shifts in at LSB
  logic [EXT_W-1:0]   dsr;     // divisor magnitude
  logic [EXT_W-1:0]   pr;      // partial remainder
  logic               q_neg;
  logic               r_neg;
  logic               dbz;
  logic               dvd_min; // dividend is the most-negative value

  logic [ABS_MAX_W:0] dvd_abs_full;
  logic [ABS_MAX_W:0] dsr_abs_full;
  logic               dsr_zero;
  logic               dvd_is_min;
  logic [EXT_W-1:0]   step_pr;
  logic               step_q;
  logic [2*WIDTH-1:0] q_fix;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   r_fix;
  logic               ovf_fix;

  // Operand magnitudes and the derived zero / most-negative indicators.
  always_comb begin
    dvd_abs_full = abs_ext({{(ABS_MAX_W-2*WIDTH){1'b0}}, i_dividend}, 2*WIDTH);
    dsr_abs_full = abs_ext({{(ABS_MAX_W-WIDTH){1'b0}}, i_divisor}, WIDTH);
    dsr_zero     = (dsr_abs_full == '0);
    dvd_is_min   = (dvd_abs_full[ABS_MAX_W:2*WIDTH-1] != '0);
  end

  serial_div_step #(.EXT_W(EXT_W)) u_step (
    .pr      (pr),
    .bit_in  (dvd[2*WIDTH-1]),
    .dsr     (dsr),
    .pr_next (step_pr),
    .q_bit   (step_q)
  );

  // Sign fix of the finished magnitudes; remainder magnitude is < |divisor|
  // so its top extended bit is never needed here.
  always_comb begin
    r_mag   = pr[WIDTH-1:0];
    q_fix   = q_neg ? (~dvd + (2*WIDTH)'(1)) : dvd;
    r_fix   = r_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    ovf_fix = dvd_min && !q_neg && (dsr == EXT_W'(1));
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      pr          <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz         <= 1'b0;
      dvd_min     <= 1'b0;
      o_ready     <= 1'b0;
      o_valid     <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_dbz       <= 1'b0;
      o_ovf       <= 1'b0;
    end else if (clr) begin
      // Abort: results keep their values but are no longer qualified.
      state   <= IDLE;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          o_ready <= 1'b1;
          if (i_valid && o_ready) begin
            o_ready <= 1'b0;
            dvd     <= dvd_abs_full[2*WIDTH-1:0];
            dsr     <= dsr_abs_full[EXT_W-1:0];
            pr      <= '0;
            q_neg   <= i_dividend[2*WIDTH-1] ^ i_divisor[WIDTH-1];
            r_neg   <= i_dividend[2*WIDTH-1];
            dvd_min <= dvd_is_min;
            dbz     <= dsr_zero;
            if (dsr_zero) begin
              // Divide-by-zero waits one extra cycle in FIX before reporting.
              state <= FIX;
              cnt   <= CNT_W'(1);
            end else begin
              state <= CALC;
              cnt   <= CNT_W'(2*WIDTH-1);
            end
          end
        end
        CALC: begin
          pr  <= step_pr;
          dvd <= {dvd[2*WIDTH-2:0], step_q};
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (dbz) begin
              o_quotient  <= '1;
              o_remainder <= '0;
              o_dbz       <= 1'b1;
              o_ovf       <= 1'b0;
            end else begin
              o_quotient  <= q_fix;
              o_remainder <= r_fix;
              o_dbz       <= 1'b0;
              o_ovf       <= ovf_fix;
            end
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
